// File: rtl/apmu_ibex_pkg.sv
// Shared PMP types, CSR addresses and the pmpcfg legalisation rule.
package apmu_ibex_pkg;

  typedef enum logic [1:0] {
    PMP_MODE_OFF   = 2'b00,
    PMP_MODE_TOR   = 2'b01,
    PMP_MODE_NA4   = 2'b10,
    PMP_MODE_NAPOT = 2'b11
  } pmp_cfg_mode_e;

  typedef struct packed {
    logic          lock;
    pmp_cfg_mode_e mode;
    logic          exec;
    logic          write;
    logic          read;
  } pmp_cfg_t;

  localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
  localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;

  // Legalise one written pmpcfg byte; bits [6:5] are simply not stored.
  function automatic pmp_cfg_t pmp_cfg_warl(input pmp_cfg_t old_cfg, input logic [7:0] wr_byte,
                                            input int unsigned granularity);
    pmp_cfg_t c;
    c.lock  = wr_byte[7];
    c.mode  = pmp_cfg_mode_e'(wr_byte[4:3]);
    c.exec  = wr_byte[2];
    c.write = wr_byte[1] & wr_byte[0];
    c.read  = wr_byte[0];
    // NA4 cannot be honoured once the granule exceeds 4 bytes
    if (granularity >= 1 && c.mode == PMP_MODE_NA4) c.mode = old_cfg.mode;
    return c;
  endfunction

  // Architectural byte view of a stored cfg entry.
  function automatic logic [7:0] pmp_cfg_byte(input pmp_cfg_t c);
    return {c.lock, 2'b00, c.mode, c.exec, c.write, c.read};
  endfunction

endpackage

// File: rtl/apmu_pmp_csr_entry.sv
// One PMP region: cfg + pmpaddr storage, lock gating and pmpaddr read shaping.
module apmu_pmp_csr_entry
  import apmu_ibex_pkg::*;
#(
  parameter int unsigned PMPGranularity = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_we,
  input  logic [7:0]  cfg_wdata,
  input  logic        addr_we,
  input  logic [31:0] addr_wdata,
  input  logic        tor_lock,
  output pmp_cfg_t    cfg_q,
  output logic [31:0] addr_q,
  output logic [31:0] addr_rd,
  output logic        changed
);

  localparam int unsigned NapotBits = (PMPGranularity >= 2) ? PMPGranularity - 1 : 0;
  localparam int unsigned OffBits   = (PMPGranularity >= 1) ? PMPGranularity : 0;
  localparam logic [31:0] NapotMask = (32'd1 << NapotBits) - 32'd1;
  localparam logic [31:0] OffMask   = (32'd1 << OffBits) - 32'd1;

  pmp_cfg_t cfg_new;
  logic     cfg_wr_en;
  logic     addr_wr_en;

  // Gate writes on the current (pre-write) lock state.
  always_comb begin
    cfg_new    = pmp_cfg_warl(cfg_q, cfg_wdata, PMPGranularity);
    cfg_wr_en  = cfg_we & ~cfg_q.lock;
    addr_wr_en = addr_we & ~cfg_q.lock & ~tor_lock;
    changed    = (cfg_wr_en && cfg_new != cfg_q) || (addr_wr_en && addr_wdata != addr_q);
  end

  // Region state; lock can only be cleared by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_q  <= '0;
      addr_q <= '0;
    end else begin
      if (cfg_wr_en)  cfg_q  <= cfg_new;
      if (addr_wr_en) addr_q <= addr_wdata;
    end
  end

  // Read view only; the stored address keeps every bit.
  always_comb begin
    addr_rd = addr_q;
    if (PMPGranularity >= 2 && cfg_q.mode == PMP_MODE_NAPOT)
      addr_rd = addr_q | NapotMask;
    else if (PMPGranularity >= 1 && (cfg_q.mode == PMP_MODE_OFF || cfg_q.mode == PMP_MODE_TOR))
      addr_rd = addr_q & ~OffMask;
  end

endmodule

// File: rtl/apmu_pmp_csr_regs.sv
// PMP CSR bank: address decode, byte steering, read mux and update pulse.
module apmu_pmp_csr_regs
  import apmu_ibex_pkg::*;
#(
  parameter int unsigned PMPGranularity = 0,
  parameter int unsigned PMPNumRegions  = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               csr_we_i,
  input  logic [11:0]                        csr_addr_i,
  input  logic [31:0]                        csr_wdata_i,
  output logic [31:0]                        csr_rdata_o,
  output logic                               csr_hit_o,
  output pmp_cfg_t [PMPNumRegions-1:0]       csr_pmp_cfg_o,
  output logic [PMPNumRegions-1:0][33:0]     csr_pmp_addr_o,
  output logic                               pmp_updated_o
);

  logic                     cfg_hit, addr_hit, cfg_sel, addr_sel;
  logic [15:0][7:0]         cfg_rd;
  logic [15:0][31:0]        addr_rd;
  logic [PMPNumRegions-1:0] changed;

  assign cfg_hit  = csr_addr_i[11:2] == CSR_PMPCFG0[11:2];
  assign addr_hit = csr_addr_i[11:4] == CSR_PMPADDR0[11:4];
  assign cfg_sel  = csr_we_i & cfg_hit;
  assign addr_sel = csr_we_i & addr_hit;

  for (genvar i = 0; i < 16; i++) begin : g_region
    if (i < PMPNumRegions) begin : g_impl
      logic        tor_lock;
      logic [31:0] stored;
      // A locked TOR region above also freezes this region's address (its base).
      if (i + 1 < PMPNumRegions) begin : g_tor
        assign tor_lock = csr_pmp_cfg_o[i+1].lock && csr_pmp_cfg_o[i+1].mode == PMP_MODE_TOR;
      end else begin : g_top
        assign tor_lock = 1'b0;
      end
      apmu_pmp_csr_entry #(.PMPGranularity(PMPGranularity)) u_entry (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cfg_we     (cfg_sel && csr_addr_i[1:0] == 2'(i / 4)),
        .cfg_wdata  (csr_wdata_i[8*(i%4) +: 8]),
        .addr_we    (addr_sel && csr_addr_i[3:0] == 4'(i)),
        .addr_wdata (csr_wdata_i),
        .tor_lock   (tor_lock),
        .cfg_q      (csr_pmp_cfg_o[i]),
        .addr_q     (stored),
        .addr_rd    (addr_rd[i]),
        .changed    (changed[i])
      );
      assign csr_pmp_addr_o[i] = {stored, 2'b00};
      assign cfg_rd[i]         = pmp_cfg_byte(csr_pmp_cfg_o[i]);
    end else begin : g_unimpl
      assign cfg_rd[i]  = 8'h00;
      assign addr_rd[i] = 32'h0;
    end
  end

  // Combinational read of whatever csr_addr_i points at.
  always_comb begin
    csr_rdata_o = 32'h0;
    csr_hit_o   = cfg_hit | addr_hit;
    if (cfg_hit)       csr_rdata_o = cfg_rd[{csr_addr_i[1:0], 2'b00} +: 4];
    else if (addr_hit) csr_rdata_o = addr_rd[csr_addr_i[3:0]];
  end

  // One-cycle pulse when the previous write altered stored state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pmp_updated_o <= 1'b0;
    else       pmp_updated_o <= |changed;
  end

endmodule

// File: tb/tb_apmu_pmp_csr_regs.sv
// Scoreboard bench: three DUTs (granule 0/1/2) share stimulus, compared to a model.
module tb_apmu_pmp_csr_regs;
  import apmu_ibex_pkg::*;

  localparam int NR = 4;
  localparam int NG = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [11:0] addr = 12'h0;
  logic [31:0] wdata = 32'h0;

  logic [31:0]           rdata [NG];
  logic                  hit   [NG];
  pmp_cfg_t [NR-1:0]     cfg_o [NG];
  logic [NR-1:0][33:0]   addr_o [NG];
  logic                  upd   [NG];

  for (genvar g = 0; g < NG; g++) begin : g_dut
    apmu_pmp_csr_regs #(.PMPGranularity(g), .PMPNumRegions(NR)) u_dut (
      .clk_i(clk), .rst_i(rst), .csr_we_i(we), .csr_addr_i(addr), .csr_wdata_i(wdata),
      .csr_rdata_o(rdata[g]), .csr_hit_o(hit[g]), .csr_pmp_cfg_o(cfg_o[g]),
      .csr_pmp_addr_o(addr_o[g]), .pmp_updated_o(upd[g])
    );
  end

  // Model: architectural pmpcfg byte and raw pmpaddr per region.
  logic [7:0]  mc [NG][16];
  logic [31:0] ma [NG][16];

  typedef struct packed {
    logic [NG-1:0][31:0]         rd;
    logic                        hit;
    logic [NG-1:0][NR-1:0][5:0]  cfg;
    logic [NG-1:0][NR-1:0][33:0] adr;
    logic [NG-1:0]               upd;
  } exp_t;

  exp_t q[$];
  int nvec = 0;
  int nerr = 0;

  function automatic logic [31:0] m_rd(int g, logic [11:0] a);
    logic [31:0] res = 32'h0;
    logic [31:0] v;
    logic [1:0]  md;
    int n, i;
    if (a >= 12'h3A0 && a <= 12'h3A3) begin
      n = int'(a - 12'h3A0);
      for (int k = 0; k < 4; k++) if (4*n + k < NR) res[8*k +: 8] = mc[g][4*n+k];
    end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
      i = int'(a - 12'h3B0);
      if (i < NR) begin
        v  = ma[g][i];
        md = mc[g][i][4:3];
        if (g >= 2 && md == 2'b11)      v = v | ((32'd1 << (g - 1)) - 32'd1);
        else if (g >= 1 && md <= 2'b01) v = v & ~((32'd1 << g) - 32'd1);
        res = v;
      end
    end
    return res;
  endfunction

  function automatic logic m_wr(int g, logic [11:0] a, logic [31:0] d);
    logic [7:0] b;
    logic       ch = 1'b0;
    int n, r, i;
    if (a >= 12'h3A0 && a <= 12'h3A3) begin
      n = int'(a - 12'h3A0);
      for (int k = 0; k < 4; k++) begin
        r = 4*n + k;
        if (r < NR && !mc[g][r][7]) begin
          b = d[8*k +: 8] & 8'h9F;
          if (b[1:0] == 2'b10) b[1] = 1'b0;
          if (g >= 1 && b[4:3] == 2'b10) b[4:3] = mc[g][r][4:3];
          if (b != mc[g][r]) ch = 1'b1;
          mc[g][r] = b;
        end
      end
    end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
      i = int'(a - 12'h3B0);
      if (i < NR && !mc[g][i][7] && !(i + 1 < NR && mc[g][i+1][7] && mc[g][i+1][4:3] == 2'b01)) begin
        if (ma[g][i] != d) ch = 1'b1;
        ma[g][i] = d;
      end
    end
    return ch;
  endfunction

  task automatic do_op(input logic r, input logic w, input logic [11:0] a, input logic [31:0] d);
    exp_t e;
    @(posedge clk);
    #2;
    rst = r; we = w; addr = a; wdata = d;
    e = '0;
    e.hit = (a >= 12'h3A0 && a <= 12'h3A3) || (a >= 12'h3B0 && a <= 12'h3BF);
    for (int g = 0; g < NG; g++) begin
      if (r) for (int k = 0; k < 16; k++) begin mc[g][k] = 8'h0; ma[g][k] = 32'h0; end
      e.rd[g] = m_rd(g, a);
      if (!r && w) e.upd[g] = m_wr(g, a, d);
      for (int k = 0; k < NR; k++) begin
        e.cfg[g][k] = {mc[g][k][7], mc[g][k][4:0]};
        e.adr[g][k] = {ma[g][k], 2'b00};
      end
    end
    q.push_back(e);
  endtask

  // Monitor: read path before the edge, registered outputs just after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q[0];
        for (int g = 0; g < NG; g++) begin
          nvec++;
          if (rdata[g] !== e.rd[g]) begin
            nerr++; $display("FAIL rdata g%0d addr=%h got %h exp %h", g, addr, rdata[g], e.rd[g]);
          end
          nvec++;
          if (hit[g] !== e.hit) begin
            nerr++; $display("FAIL hit g%0d addr=%h got %b exp %b", g, addr, hit[g], e.hit);
          end
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < NG; g++) begin
          for (int k = 0; k < NR; k++) begin
            nvec++;
            if (6'(cfg_o[g][k]) !== e.cfg[g][k]) begin
              nerr++; $display("FAIL cfg g%0d r%0d got %h exp %h", g, k, 6'(cfg_o[g][k]), e.cfg[g][k]);
            end
            nvec++;
            if (addr_o[g][k] !== e.adr[g][k]) begin
              nerr++; $display("FAIL pmp_addr g%0d r%0d got %h exp %h", g, k, addr_o[g][k], e.adr[g][k]);
            end
          end
          nvec++;
          if (upd[g] !== e.upd[g]) begin
            nerr++; $display("FAIL updated g%0d got %b exp %b", g, upd[g], e.upd[g]);
          end
        end
        void'(q.pop_front());
      end
    end
  end

  initial begin
    logic [11:0] a;
    logic [31:0] d;
    // reset and idle reads
    do_op(1, 0, 12'h3A0, 0);
    do_op(0, 0, 12'h3A0, 0);
    do_op(0, 0, 12'h3B0, 0);
    do_op(0, 0, 12'h3C0, 0);
    // NAPOT RWX, repeated write must not pulse
    do_op(0, 1, 12'h3A0, 32'h0000_001F);
    do_op(0, 1, 12'h3A0, 32'h0000_001F);
    do_op(0, 0, 12'h3A0, 0);
    // W without R, then NA4 over TOR
    do_op(0, 1, 12'h3A0, 32'h0000_0002);
    do_op(0, 1, 12'h3A0, 32'h0000_0008);
    do_op(0, 1, 12'h3A0, 32'h0000_0010);
    do_op(0, 0, 12'h3A0, 0);
    // locked TOR region1 freezes pmpaddr0 and its own byte
    do_op(1, 0, 12'h3A0, 0);
    do_op(0, 1, 12'h3B0, 32'h0000_0055);
    do_op(0, 1, 12'h3A0, 32'h0000_8800);
    do_op(0, 1, 12'h3B0, 32'h0000_1234);
    do_op(0, 0, 12'h3B0, 0);
    do_op(0, 1, 12'h3A0, 32'h0000_0000);
    do_op(0, 0, 12'h3A0, 0);
    do_op(0, 1, 12'h3B1, 32'hFFFF_FFFF);
    // read-back shaping
    do_op(1, 0, 12'h3A0, 0);
    do_op(0, 1, 12'h3B0, 32'h0000_0100);
    do_op(0, 1, 12'h3A0, 32'h0000_0018);
    do_op(0, 0, 12'h3B0, 0);
    do_op(0, 1, 12'h3A0, 32'h0000_0000);
    do_op(0, 0, 12'h3B0, 0);
    do_op(0, 1, 12'h3B0, 32'h0000_00FF);
    do_op(0, 0, 12'h3B0, 0);
    // reset mid-write while locked, then writes accepted again
    do_op(0, 1, 12'h3A0, 32'h0000_009F);
    do_op(1, 1, 12'h3A0, 32'h0000_0000);
    do_op(0, 1, 12'h3A0, 32'h0000_001B);
    do_op(0, 1, 12'h3B0, 32'h0000_0ABC);
    do_op(0, 0, 12'h3A0, 0);
    // random traffic
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 12'h3A0 + 12'($urandom_range(0, 3));
        4, 5, 6, 7: a = 12'h3B0 + 12'($urandom_range(0, 15));
        default:    a = 12'($urandom);
      endcase
      d = $urandom;
      if ($urandom_range(0, 15) != 0) d = d & 32'h7F7F_7F7F;
      do_op(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), a, d);
    end
    for (int t = 0; t < 20 && q.size() != 0; t++) begin
      @(posedge clk);
      #2;
    end
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain pending=%0d exp 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/apmu_pmp_csr_regs.md
Name: apmu_pmp_csr_regs

Overview:
Holds the machine-mode PMP configuration and address CSRs (pmpcfg0-3, pmpaddr0-15) and implements their write, lock and WARL rules. It drives the per-region cfg/addr vectors consumed directly by the PMP access checker. It is the upstream stage of that checker, sitting between the CSR file write/read path and the checker's csr_pmp_cfg_i/csr_pmp_addr_i inputs.

Parameters:
PMPGranularity, 0, NAPOT granule G: 0 = 4 byte, 1 = 8 byte, 2 = 16 byte, and so on; must match the checker.
PMPNumRegions, 4, number of implemented regions, 1..16; unimplemented entries are read-only zero.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
csr_we_i  in  1  write strobe, one write per cycle
csr_addr_i  in  12  CSR address for both read and write
csr_wdata_i  in  32  write data
csr_rdata_o  out  32  combinational read data for csr_addr_i
csr_hit_o  out  1  csr_addr_i is in 0x3A0-0x3A3 or 0x3B0-0x3BF
csr_pmp_cfg_o  out  pmp_cfg_t[PMPNumRegions]  per-region lock/mode/exec/write/read
csr_pmp_addr_o  out  34[PMPNumRegions]  {pmpaddr[31:0], 2'b00}
pmp_updated_o  out  1  one-cycle pulse after any write that changed stored state

Behaviour:
- Reset (async, rst_i=1): all cfg fields 0 (mode OFF, unlocked), all pmpaddr 0, pmp_updated_o=0. Outputs are registers, so outputs equal the reset values while reset is asserted.
- Address map:
  - pmpcfgN at 0x3A0+N; byte k maps to region 4N+k, using L[7], A[4:3], X[2], W[1], R[0].
  - pmpaddrN at 0x3B0+N holds bits [33:2] of the region address.
- Write latency: a write with csr_we_i=1 in cycle N is visible on csr_pmp_cfg_o / csr_pmp_addr_o and csr_rdata_o in cycle N+1. No stall and no handshake; every write is accepted.
- A write to a non-hit address, or to an unimplemented region, is ignored.
- Byte-wise pmpcfg write: each byte is evaluated independently.
  - Byte i is ignored entirely if cfg[i].lock=1.
  - Otherwise the byte is stored subject to these WARL rules:
    - Bits [6:5] are always written as 0.
    - W=1 with R=0 is reserved: store W=0, other fields as written.
    - A=NA4 while PMPGranularity>=1: mode keeps its previous value, other fields as written.
- pmpaddr i write is ignored if:
  - cfg[i].lock=1, or
  - cfg[i+1].lock=1 with cfg[i+1].mode=TOR (only when i+1 < PMPNumRegions).
- Simultaneous events: a lock set by a write in cycle N affects writes from cycle N+1 onward. A single pmpcfg write is evaluated against the pre-write lock bits of all four of its bytes.
- Lock bits can only be cleared by reset.
- pmpaddr read-back; the stored value keeps all bits and only the read view is shaped:
  - G>=2 and mode NAPOT: bits [G-2:0] read as 1.
  - G>=1 and mode OFF or TOR: bits [G-1:0] read as 0.
  - Otherwise: read back as stored.
- csr_pmp_addr_o always carries the unshaped stored value. The checker applies its own granularity masking.
- Reads:
  - Unimplemented-region bytes and addresses read 0.
  - Non-hit addresses read 0 with csr_hit_o=0.
- pmp_updated_o: registered; asserted in cycle N+1 when the write in cycle N changed at least one stored bit. A write that is fully ignored, or that stores identical values, does not pulse.
- Reset asserted mid-sequence: state clears immediately; no pulse on reset release.

Decomposition:
- Package apmu_ibex_pkg holds the shared types and constants:
  - pmp_cfg_t and the PMP mode enum (OFF/TOR/NA4/NAPOT), reused from the checker.
  - CSR address constants CSR_PMPCFG0 and CSR_PMPADDR0.
  - A function pmp_cfg_warl(old_cfg, wr_byte, granularity) returning the legalised pmp_cfg_t.
- One sub-module, apmu_pmp_csr_entry: a single-region register with lock and TOR-lock gating and read-back shaping. The top level instantiates PMPNumRegions copies and does address decode, byte steering and read muxing.

Test Plan:
- Reset, then read 0x3A0 and 0x3B0 -> 0, csr_hit_o=1; read 0x3C0 -> 0, csr_hit_o=0.
- Write 0x3A0=0x0000_001F with G=0 -> region0 {L=0, A=NAPOT, X=1, W=1, R=1} on the next cycle, pmp_updated_o pulses once. Repeat the same write -> no pulse.
- Write byte 0x02 (W only) -> stored as 0x00. With G=1, write A=NA4 over mode TOR -> mode remains TOR.
- Set region1 cfg=0x88 (L=1, TOR). Then write pmpaddr0=0x1234 -> ignored, reads old value. Write pmpcfg byte1=0x00 -> ignored, lock persists until rst_i.
- G=2, pmpaddr0=0x0000_0100, mode NAPOT -> reads 0x101, csr_pmp_addr_o=0x400. Switch mode to OFF -> reads 0x100.
- Assert rst_i while region0 is locked, mid-write -> all outputs 0 asynchronously. After release, writes to region0 are accepted.
